// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler slice.
//   uart_sched_state_t : FSM encoding used by uart_tx_sched
//   UART_DATA_BITS     : default byte width, matches the serializer
//   uart_cnt_width()   : width of a saturating counter that must reach a value t
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        WAIT    = 2'd3
    } uart_sched_state_t;

    // A zero-valued limit still needs a 1-bit counter so the design elaborates.
    function automatic int uart_cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req   in  N        request vector
//   ptr   in  log2(N)  highest-priority index; search runs ptr, ptr+1, ... mod N
//   found out 1        at least one request set
//   idx   out log2(N)  first requesting index at or after ptr
module rr_pick #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  pos;
    logic [IW:0]    sum;

    // Rotating the doubled vector puts ptr at bit 0, so a plain
    // lowest-set-bit search gives the round-robin order.
    always_comb begin
        dbl   = {req, req};
        rot   = dbl[ptr +: N];
        found = 1'b0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pos   = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, pos};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-level round-robin scheduler sharing one UART TX serializer among
// NUM_REQ byte-stream requesters. A grant is held from a packet's first byte
// until its last byte, or until the owner stays silent for TIMEOUT cycles.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_data     requester i byte at [i*DATA_BITS +: DATA_BITS]
//   req_valid    requester i has a byte
//   req_last     byte closes its packet
//   req_ready    one-hot acceptance pulse
//   tx_data      byte to serializer, stable while tx_valid
//   tx_valid     level request to serializer
//   tx_ready     serializer frame complete
//   grant        index of the owning requester
//   busy         grant locked
//
// state   | meaning
// IDLE    | no owner; round-robin pick from rr_ptr, accept and lock
// SEND    | tx_valid high with the held byte until tx_ready
// RELEASE | one cycle with tx_valid low; end packet or go wait for more
// WAIT    | owner locked, waiting for its next byte or the idle timeout
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int TIMEOUT   = 1024,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [GW-1:0]                  grant,
    output logic                           busy
);

    localparam int CW = uart_cnt_width(TIMEOUT);

    uart_sched_state_t    state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 last_q, last_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        idle_q, idle_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic                 accept;
    logic [GW-1:0]        acc_idx;
    logic [GW-1:0]        next_ptr;
    logic                 grant_valid;
    logic                 idle_expired;

    logic [DATA_BITS-1:0] lane [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
    end

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_valid  = req_valid[grant_q];
    assign next_ptr     = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
    // TIMEOUT of zero disables forced release entirely.
    assign idle_expired = (TIMEOUT > 0) && (idle_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        last_d   = last_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        idle_d   = idle_q;
        accept   = 1'b0;
        acc_idx  = grant_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    accept  = 1'b1;
                    acc_idx = pick_idx;
                    grant_d = pick_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (last_q) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else begin
                    idle_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A byte arriving on the expiry cycle still wins, so nothing is dropped.
                if (grant_valid) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end else if (idle_expired) begin
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end else if (idle_q != {CW{1'b1}}) begin
                    idle_d = idle_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            hold_d = lane[acc_idx];
            last_d = req_last[acc_idx];
            idle_d = '0;
        end
    end

    // req_ready is a Mealy output so the acceptance pulse lines up with the
    // edge that latches the byte; it is masked during reset so a requester
    // never sees a byte taken that the reset edge discards.
    always_comb begin
        req_ready = '0;
        if (accept && !rst) begin
            req_ready[acc_idx] = 1'b1;
        end
    end

    assign tx_valid = (state_q == SEND);
    assign tx_data  = hold_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            last_q   <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            idle_q   <= idle_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DB-1:0]   tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [1:0]      grant;
    logic            busy;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ   (N),
        .DATA_BITS (DB),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } ent_t;

    ent_t rq [N][$];

    int errors = 0;
    int checks = 0;
    int fixed_dly = 5;
    bit noise_en = 1'b0;

    int glog [$];
    int blog [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_log(input string name, input int act[$], input int exp[$]);
        chk({name, " length"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++) begin
            chk(name, act[i], exp[i]);
        end
    endtask

    // Requesters: present queued bytes after their gap, hold until accepted,
    // scramble the data lane whenever not valid.
    initial begin
        logic [N-1:0] acc_s;
        logic         rst_s;
        int           gapc [N];
        bit           pres [N];
        ent_t         e;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            gapc[i] = 0;
            pres[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            acc_s = req_ready;
            rst_s = rst;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rst_s) begin
                    pres[i]      = 1'b0;
                    req_valid[i] = 1'b0;
                    gapc[i]      = 0;
                end else if (pres[i] && acc_s[i]) begin
                    pres[i]      = 1'b0;
                    req_valid[i] = 1'b0;
                end
                if (!pres[i] && !rst_s && rq[i].size() > 0) begin
                    if (gapc[i] < rq[i][0].gap) begin
                        gapc[i]++;
                    end else begin
                        e = rq[i].pop_front();
                        req_data[i*DB +: DB] = e.data;
                        req_last[i]          = e.last;
                        req_valid[i]         = 1'b1;
                        pres[i]              = 1'b1;
                        gapc[i]              = 0;
                    end
                end
                if (!pres[i]) begin
                    req_data[i*DB +: DB] = 8'($urandom);
                    req_last[i]          = 1'($urandom);
                end
            end
        end
    end

    // Serializer stub: completes a frame dly cycles into tx_valid, holds
    // tx_ready until tx_valid drops; optional noise while idle.
    initial begin
        int cnt;
        int dly;
        bit was;
        tx_ready = 1'b0;
        cnt = 0;
        dly = 0;
        was = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_valid) begin
                if (!was) begin
                    cnt = 0;
                    dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4));
                end
                if (cnt >= dly) begin
                    tx_ready = 1'b1;
                end else begin
                    tx_ready = 1'b0;
                    cnt++;
                end
            end else begin
                tx_ready = noise_en ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            was = tx_valid;
        end
    end

    // Reference model: owner/pointer bookkeeping from the scheduling rules,
    // compared against the DUT every cycle.
    initial begin
        int         m_owner;
        int         m_grant;
        int         m_ptr;
        int         m_idle;
        bit         m_send;
        bit         m_gap;
        bit         m_last;
        logic [7:0] m_byte;
        int         acc;
        logic [N-1:0] exp_rdy;
        m_owner = -1; m_grant = 0; m_ptr = 0; m_idle = 0;
        m_send = 0; m_gap = 0; m_last = 0; m_byte = '0;
        forever begin
            @(negedge clk);
            acc = -1;
            if (!rst && !m_send && !m_gap) begin
                if (m_owner < 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (acc < 0 && req_valid[(m_ptr + k) % N]) acc = (m_ptr + k) % N;
                    end
                end else if (req_valid[m_owner]) begin
                    acc = m_owner;
                end
            end
            exp_rdy = '0;
            if (acc >= 0) exp_rdy[acc] = 1'b1;
            chk("model req_ready", req_ready, exp_rdy);
            chk("req_ready onehot", $countones(req_ready) <= 1, 1);
            chk("model tx_valid", tx_valid, m_send);
            chk("model busy", busy, m_owner >= 0);
            chk("model grant", grant, m_grant);
            if (m_send) chk("model tx_data", tx_data, m_byte);

            if (rst) begin
                m_owner = -1; m_grant = 0; m_ptr = 0; m_idle = 0;
                m_send = 0; m_gap = 0; m_last = 0; m_byte = '0;
                glog.delete();
                blog.delete();
            end else if (acc >= 0) begin
                m_send  = 1;
                m_byte  = req_data[acc*DB +: DB];
                m_last  = req_last[acc];
                m_owner = acc;
                m_grant = acc;
                m_idle  = 0;
                glog.push_back(acc);
                blog.push_back(int'(m_byte));
            end else if (m_send) begin
                if (tx_ready) begin
                    m_send = 0;
                    m_gap  = 1;
                end
            end else if (m_gap) begin
                m_gap  = 0;
                m_idle = 0;
                if (m_last) begin
                    m_owner = -1;
                    m_ptr   = (m_grant + 1) % N;
                end
            end else if (m_owner >= 0) begin
                if (m_idle == TO - 1) begin
                    m_owner = -1;
                    m_ptr   = (m_grant + 1) % N;
                end else begin
                    m_idle++;
                end
            end
        end
    end

    task automatic put(input int i, input logic [7:0] d, input logic l, input int g);
        ent_t e;
        e.data = d;
        e.last = l;
        e.gap  = g;
        rq[i].push_back(e);
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int quiet;
        bit empty;
        quiet = 0;
        for (int c = 0; c < budget && quiet < 3; c++) begin
            @(negedge clk);
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (rq[i].size() != 0) empty = 1'b0;
            if (empty && req_valid == '0 && !busy && !tx_valid) quiet++;
            else quiet = 0;
        end
        chk({name, " drained"}, quiet >= 3, 1);
    endtask

    initial begin
        int exp_q [$];
        int sends;
        int run;
        bit seen;
        bit dropped;

        // Single-byte packet from requester 1, stub completes after 5 cycles.
        fixed_dly = 5;
        noise_en  = 1'b0;
        assert_reset();
        put(1, 8'h55, 1'b1, 0);
        release_reset();
        @(negedge clk);
        chk("reset req_ready", req_ready, 0);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset grant", grant, 0);
        chk("reset busy", busy, 0);
        @(negedge clk);
        chk("t1 req_ready", req_ready, 4'b0010);
        @(negedge clk);
        chk("t1 tx_valid", tx_valid, 1);
        chk("t1 tx_data", tx_data, 8'h55);
        chk("t1 grant", grant, 1);
        sends = 0;
        for (int c = 0; c < 30 && tx_valid; c++) begin
            sends++;
            @(negedge clk);
        end
        chk("t1 send cycles", sends, 6);
        chk("t1 release tx_valid", tx_valid, 0);
        chk("t1 release busy", busy, 1);
        @(negedge clk);
        chk("t1 idle busy", busy, 0);
        put(0, 8'hC0, 1'b1, 0);
        put(1, 8'hC1, 1'b1, 0);
        put(2, 8'hC2, 1'b1, 0);
        @(negedge clk);
        chk("t1 rr_ptr=2 pick", req_ready, 4'b0100);
        wait_idle("t1", 300);
        exp_q = {1, 2, 0, 1};
        cmp_log("t1 grants", glog, exp_q);
        exp_q = {'h55, 'hC2, 'hC0, 'hC1};
        cmp_log("t1 bytes", blog, exp_q);

        // All four valid with single-byte packets.
        fixed_dly = -1;
        assert_reset();
        put(0, 8'hB0, 1'b1, 0);
        put(0, 8'hB4, 1'b1, 0);
        put(1, 8'hB1, 1'b1, 0);
        put(2, 8'hB2, 1'b1, 0);
        put(3, 8'hB3, 1'b1, 0);
        release_reset();
        wait_idle("t2", 300);
        exp_q = {0, 1, 2, 3, 0};
        cmp_log("t2 grants", glog, exp_q);
        exp_q = {'hB0, 'hB1, 'hB2, 'hB3, 'hB4};
        cmp_log("t2 bytes", blog, exp_q);

        // Multi-byte packet keeps the grant against a waiting requester.
        noise_en = 1'b1;
        assert_reset();
        put(0, 8'hA1, 1'b0, 0);
        put(0, 8'hA2, 1'b0, 0);
        put(0, 8'hA3, 1'b1, 0);
        put(2, 8'h2B, 1'b1, 0);
        release_reset();
        wait_idle("t3", 300);
        exp_q = {'hA1, 'hA2, 'hA3, 'h2B};
        cmp_log("t3 bytes", blog, exp_q);

        // Idle timeout releases a silent owner.
        noise_en  = 1'b0;
        fixed_dly = 2;
        assert_reset();
        put(3, 8'h10, 1'b0, 0);
        put(0, 8'h20, 1'b1, 5);
        release_reset();
        run  = 0;
        seen = 1'b0;
        dropped = 1'b0;
        for (int c = 0; c < 200 && !dropped; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
            if (seen && busy && !tx_valid) run++;
            if (seen && run > 0 && !busy) dropped = 1'b1;
        end
        chk("t4 busy run before release", run, 17);
        wait_idle("t4", 300);
        exp_q = {3, 0};
        cmp_log("t4 grants", glog, exp_q);
        exp_q = {'h10, 'h20};
        cmp_log("t4 bytes", blog, exp_q);

        // tx_data held while the requester lane scrambles.
        fixed_dly = 8;
        assert_reset();
        put(2, 8'h3C, 1'b1, 0);
        release_reset();
        sends = 0;
        seen  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_valid) begin
                seen = 1'b1;
                sends++;
                chk("t5 stable tx_data", tx_data, 8'h3C);
            end else if (seen) begin
                break;
            end
        end
        chk("t5 send cycles", sends, 9);
        wait_idle("t5", 200);

        // Reset in the middle of a frame.
        fixed_dly = 20;
        assert_reset();
        put(1, 8'h77, 1'b0, 0);
        release_reset();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        chk("t6 reached send", seen, 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t6 tx_valid after rst", tx_valid, 0);
        chk("t6 busy after rst", busy, 0);
        chk("t6 grant after rst", grant, 0);
        fixed_dly = 3;
        put(3, 8'h99, 1'b1, 0);
        wait_idle("t6", 200);
        exp_q = {3};
        cmp_log("t6 grants", glog, exp_q);
        exp_q = {'h99};
        cmp_log("t6 bytes", blog, exp_q);

        // Randomized traffic, occasional mid-packet stalls past the timeout.
        fixed_dly = -1;
        noise_en  = 1'b1;
        assert_reset();
        for (int i = 0; i < N; i++) begin
            int npk;
            npk = int'($urandom_range(3, 6));
            for (int p = 0; p < npk; p++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    int g;
                    if (b == 0) g = int'($urandom_range(0, 6));
                    else if ($urandom_range(0, 5) == 0) g = 18;
                    else g = int'($urandom_range(0, 3));
                    put(i, 8'($urandom), b == len - 1, g);
                end
            end
        end
        release_reset();
        wait_idle("random", 6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
